// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the write-back stage: memory-to-WB bus layout, CP0 addresses, ExcCodes.
// Optional Count/Compare timer is selected by the CP0_TIMER_EN macro.
package wb_stage_pkg;

    localparam int MS_TO_WS_BUS_WD = 148;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Field order is MSB first and must match the memory stage packing.
    typedef struct packed {
        logic        eret;
        logic        mtc0_we;
        logic [4:0]  cp0_addr;
        logic        res_from_cp0;
        logic [31:0] alu_result;
        logic        ex;
        logic [4:0]  excode;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] rt_value;
        logic [31:0] pc;
    } ms_to_ws_bus_t;

endpackage

// File: rtl/wb_stage_cp0_regfile.sv
// CP0 storage (Status/Cause/EPC and, with CP0_TIMER_EN, Count/Compare), read mux and interrupt-pending logic.
// Without CP0_TIMER_EN the timer registers read as zero and ignore writes.
module cp0_regfile
    import wb_stage_pkg::*;
#(
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  ext_int_i,
    input  logic        ex_commit_i,
    input  logic [4:0]  ex_code_i,
    input  logic [31:0] ex_pc_i,
    input  logic        eret_commit_i,
    input  logic        mtc0_we_i,
    input  logic [4:0]  cp0_addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [31:0] epc_o,
    output logic        int_pend_o
);

    logic [7:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic [1:0]  ip_sw_q;
    logic [5:0]  ip_hw_q;
    logic [4:0]  exccode_q;
    logic [31:0] epc_q;
    logic [31:0] count_rd;
    logic [31:0] compare_rd;
    logic        ti_rd;
    logic [7:0]  ip;
    logic [31:0] status_rd;
    logic [31:0] cause_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q      <= STATUS_RST[15:8];
            exl_q     <= STATUS_RST[1];
            ie_q      <= STATUS_RST[0];
            ip_sw_q   <= 2'b00;
            ip_hw_q   <= 6'b0;
            exccode_q <= 5'd0;
            epc_q     <= 32'h0;
        end else begin
            ip_hw_q <= ext_int_i;
            if (ex_commit_i) begin
                // A nested exception keeps the EPC of the outermost one.
                if (!exl_q) epc_q <= ex_pc_i;
                exccode_q <= ex_code_i;
                exl_q     <= 1'b1;
            end else if (eret_commit_i) begin
                exl_q <= 1'b0;
            end
            if (mtc0_we_i) begin
                case (cp0_addr_i)
                    CP0_STATUS: begin
                        im_q  <= wdata_i[15:8];
                        exl_q <= wdata_i[1];
                        ie_q  <= wdata_i[0];
                    end
                    CP0_CAUSE: ip_sw_q <= wdata_i[9:8];
                    CP0_EPC:   epc_q   <= wdata_i;
                    default: ;
                endcase
            end
        end
    end

`ifdef CP0_TIMER_EN
    logic        tick_q;
    logic        ti_q;
    logic [31:0] count_q;
    logic [31:0] compare_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q    <= 1'b0;
            ti_q      <= 1'b0;
            count_q   <= 32'h0;
            compare_q <= 32'h0;
        end else begin
            tick_q <= ~tick_q;
            if (mtc0_we_i && cp0_addr_i == CP0_COUNT) count_q <= wdata_i;
            else if (tick_q)                          count_q <= count_q + 32'd1;
            if (mtc0_we_i && cp0_addr_i == CP0_COMPARE) begin
                compare_q <= wdata_i;
                ti_q      <= 1'b0;
            end else if (count_q == compare_q) begin
                ti_q <= 1'b1;
            end
        end
    end

    assign count_rd   = count_q;
    assign compare_rd = compare_q;
    assign ti_rd      = ti_q;
`else
    assign count_rd   = 32'h0;
    assign compare_rd = 32'h0;
    assign ti_rd      = 1'b0;
`endif

    assign ip        = {ti_rd | ip_hw_q[5], ip_hw_q[4:0], ip_sw_q};
    assign status_rd = {STATUS_RST[31:16], im_q, STATUS_RST[7:2], exl_q, ie_q};
    assign cause_rd  = {1'b0, ti_rd, 14'b0, ip, 1'b0, exccode_q, 2'b00};

    always_comb begin
        rdata_o = 32'h0;
        case (cp0_addr_i)
            CP0_COUNT:   rdata_o = count_rd;
            CP0_COMPARE: rdata_o = compare_rd;
            CP0_STATUS:  rdata_o = status_rd;
            CP0_CAUSE:   rdata_o = cause_rd;
            CP0_EPC:     rdata_o = epc_q;
            default:     rdata_o = 32'h0;
        endcase
    end

    assign epc_o      = epc_q;
    assign int_pend_o = ie_q && !exl_q && |(ip & im_q);

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: holds the last pipeline register, commits to the GPR file and resolves exceptions/ERET.
// Count/Compare timer inside cp0_regfile is enabled by the CP0_TIMER_EN macro.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter logic [31:0] EX_ENTRY   = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       ws_allowin,
    input  logic                       ms_to_ws_valid,
    input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic [5:0]                 ext_int_in,
    output logic                       rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [31:0]                rf_wdata,
    output logic                       ex_from_ws,
    output logic [31:0]                ex_target_pc,
    output logic [31:0]                debug_wb_pc,
    output logic [3:0]                 debug_wb_rf_wen,
    output logic [4:0]                 debug_wb_rf_wnum,
    output logic [31:0]                debug_wb_rf_wdata
);

    ms_to_ws_bus_t bus_q, bus_d;
    logic          ws_valid_q, ws_valid_d;
    logic          ws_ready_go;
    logic          int_pend;
    logic          take_ex;
    logic          eret_commit;
    logic          mtc0_we;
    logic [4:0]    ex_code;
    logic [31:0]   cp0_rdata;
    logic [31:0]   epc;
    logic          unused_alu;

    assign ws_ready_go = 1'b1;
    assign ws_allowin  = !ws_valid_q || ws_ready_go;

    // A flush leaving WB this cycle also kills whatever the memory stage offers now.
    always_comb begin
        ws_valid_d = ws_valid_q;
        bus_d      = bus_q;
        if (ws_allowin) ws_valid_d = ms_to_ws_valid && !ex_from_ws;
        if (ms_to_ws_valid && ws_allowin) bus_d = ms_to_ws_bus;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid_q <= 1'b0;
            bus_q      <= '0;
        end else begin
            ws_valid_q <= ws_valid_d;
            bus_q      <= bus_d;
        end
    end

    // Interrupts win over a synchronous exception carried on the bus.
    assign take_ex     = ws_valid_q && (bus_q.ex || int_pend);
    assign ex_code     = int_pend ? EXC_INT : bus_q.excode;
    assign eret_commit = ws_valid_q && bus_q.eret && !take_ex;
    assign mtc0_we     = ws_valid_q && bus_q.mtc0_we && !take_ex;

    assign ex_from_ws   = take_ex || (ws_valid_q && bus_q.eret);
    assign ex_target_pc = take_ex ? EX_ENTRY : epc;

    assign rf_we    = ws_valid_q && bus_q.gr_we && !take_ex;
    assign rf_waddr = bus_q.dest;
    assign rf_wdata = bus_q.res_from_cp0 ? cp0_rdata : bus_q.final_result;

    assign debug_wb_pc       = bus_q.pc;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

    assign unused_alu = ^bus_q.alu_result;

    cp0_regfile #(
        .STATUS_RST(STATUS_RST)
    ) u_cp0 (
        .clk          (clk),
        .reset        (reset),
        .ext_int_i    (ext_int_in),
        .ex_commit_i  (take_ex),
        .ex_code_i    (ex_code),
        .ex_pc_i      (bus_q.pc),
        .eret_commit_i(eret_commit),
        .mtc0_we_i    (mtc0_we),
        .cp0_addr_i   (bus_q.cp0_addr),
        .wdata_i      (bus_q.rt_value),
        .rdata_o      (cp0_rdata),
        .epc_o        (epc),
        .int_pend_o   (int_pend)
    );

endmodule
